hdmi_line_fetch_sched: RTL

Line-fetch scheduler that sits between the HDMI timing generator and the frame-buffer memory reader. It issues burst read requests to the reader so that display lines are prefetched into an external two-slot (ping-pong) line buffer ahead of the timing generator consuming them. It tracks slot occupancy, generates frame and line addresses, and flags underflow when an active line starts with no filled slot.

---
 rtl/hdmi_fetch_pkg.sv | 25 ++
 rtl/hdmi_line_fetch_sched_edge_det.sv | 24 ++
 rtl/hdmi_line_fetch_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_fetch_pkg.sv
// Shared state encoding and burst-split helpers for the HDMI line-fetch scheduler.
package hdmi_fetch_pkg;

    localparam int RD_LEN_W = 9;

    typedef enum logic [2:0] {
        ST_WAIT_FRAME,
        ST_REQ,
        ST_BUSY,
        ST_NEXT,
        ST_FULL,
        ST_DONE
    } fetch_state_t;

    // Number of bursts needed to cover one active line.
    function automatic int burst_count(input int line_words, input int burst_max);
        return (line_words + burst_max - 1) / burst_max;
    endfunction

    // Length of the final (possibly short) burst of a line.
    function automatic int burst_rem(input int line_words, input int burst_max);
        return line_words - (burst_count(line_words, burst_max) - 1) * burst_max;
    endfunction

endpackage

// File: rtl/hdmi_line_fetch_sched_edge_det.sv
// Registered rise/fall detector: edges are reported in the cycle the input differs
// from its registered copy.
module edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;
    assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/hdmi_line_fetch_sched.sv
// Line-fetch scheduler: prefetches display lines into a two-slot line buffer via burst reads.
// Define FETCH_UFLOW_CNT_EN to build the saturating underflow event counter.
module hdmi_line_fetch_sched
    import hdmi_fetch_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int FRAME_BASE  = 0,
    parameter int LINE_WORDS  = 800,
    parameter int LINE_STRIDE = 1024,
    parameter int V_LINES     = 600,
    parameter int BURST_MAX   = 256
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    input  logic                video_vs,
    input  logic                video_de,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [RD_LEN_W-1:0] rd_len,
    input  logic                rd_ack,
    input  logic                rd_done,
    output logic                fill_slot,
    output logic                read_slot,
    output logic                fetch_busy,
    output logic                underflow,
    output logic [15:0]         uflow_cnt
);

    localparam int NBURST = burst_count(LINE_WORDS, BURST_MAX);
    localparam int REM    = burst_rem(LINE_WORDS, BURST_MAX);
    localparam int IDX_W  = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int LC_W   = $clog2(V_LINES + 1);

    localparam logic [RD_LEN_W-1:0] LEN_FULL  = RD_LEN_W'(BURST_MAX);
    localparam logic [RD_LEN_W-1:0] LEN_LAST  = RD_LEN_W'(REM);
    localparam logic [RD_LEN_W-1:0] LEN_FIRST = (NBURST == 1) ? LEN_LAST : LEN_FULL;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NBURST - 1);
    localparam logic [LC_W-1:0]     LC_END    = LC_W'(V_LINES);
    localparam logic [ADDR_W-1:0]   BASE      = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0]   STRIDE    = ADDR_W'(LINE_STRIDE);

    fetch_state_t        r_state;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [RD_LEN_W-1:0] r_rd_len;
    logic                r_fetch_busy;
    logic                r_fs_pend;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [IDX_W-1:0]    r_burst_idx;
    logic [LC_W-1:0]     r_line_cnt;
    logic [1:0]          r_count;
    logic                r_fill_slot;
    logic                r_read_slot;
    logic                r_underflow;
    logic                r_skip_le;

    logic w_fs;
    logic w_vs_rise_unused;
    logic w_ls;
    logic w_le;
    logic w_done_ok;
    logic w_line_inc;
    logic w_release;
    logic w_uflow;

    edge_det u_vs_edge (
        .i_clk   (pixel_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (video_vs),
        .o_rise  (w_vs_rise_unused),
        .o_fall  (w_fs)
    );

    edge_det u_de_edge (
        .i_clk   (pixel_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (video_de),
        .o_rise  (w_ls),
        .o_fall  (w_le)
    );

    // A burst whose frame was restarted while it was in flight is discarded.
    assign w_done_ok  = (r_state == ST_BUSY) && rd_done && !r_fs_pend && !w_fs;
    assign w_line_inc = w_done_ok && (r_burst_idx == IDX_LAST);
    assign w_release  = w_le && !r_skip_le && (r_count != 2'd0);
    assign w_uflow    = w_ls && (r_count == 2'd0);

    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            r_state      <= ST_WAIT_FRAME;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_len     <= '0;
            r_fetch_busy <= 1'b0;
            r_fs_pend    <= 1'b0;
            r_line_addr  <= '0;
            r_burst_idx  <= '0;
            r_line_cnt   <= '0;
            r_count      <= '0;
            r_fill_slot  <= 1'b0;
            r_read_slot  <= 1'b0;
            r_underflow  <= 1'b0;
            r_skip_le    <= 1'b0;
        end else begin
            if (w_fs) begin
                r_count     <= '0;
                r_fill_slot <= 1'b0;
                r_read_slot <= 1'b0;
                r_underflow <= 1'b0;
                r_skip_le   <= 1'b0;
                r_line_cnt  <= '0;
                r_line_addr <= BASE;
                r_burst_idx <= '0;
            end else begin
                r_count <= r_count + {1'b0, w_line_inc} - {1'b0, w_release};
                if (w_line_inc) r_fill_slot <= ~r_fill_slot;
                if (w_release)  r_read_slot <= ~r_read_slot;
                if (w_uflow) begin
                    r_underflow <= 1'b1;
                    r_skip_le   <= 1'b1;
                end else if (w_le) begin
                    r_skip_le <= 1'b0;
                end
                if (w_done_ok) begin
                    if (w_line_inc) begin
                        r_line_addr <= r_line_addr + STRIDE;
                        r_line_cnt  <= r_line_cnt + LC_W'(1);
                        r_burst_idx <= '0;
                    end else begin
                        r_burst_idx <= r_burst_idx + IDX_W'(1);
                    end
                end
            end

            unique case (r_state)
                ST_WAIT_FRAME, ST_DONE: begin
                    if (w_fs) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= BASE;
                        r_rd_len  <= LEN_FIRST;
                    end
                end
                ST_FULL: begin
                    if (w_fs) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= BASE;
                        r_rd_len  <= LEN_FIRST;
                    end else if (r_count < 2'd2) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_line_addr;
                        r_rd_len  <= LEN_FIRST;
                    end
                end
                ST_REQ: begin
                    if (r_rd_req && rd_ack) begin
                        r_state      <= ST_BUSY;
                        r_rd_req     <= 1'b0;
                        r_fetch_busy <= 1'b1;
                        if (w_fs) r_fs_pend <= 1'b1;
                    end else if (w_fs) begin
                        // Withdraw for one cycle so the reader never sees the address change under rd_req.
                        r_rd_req  <= 1'b0;
                        r_rd_addr <= BASE;
                        r_rd_len  <= LEN_FIRST;
                    end else begin
                        r_rd_req <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (rd_done) begin
                        r_fetch_busy <= 1'b0;
                        if (r_fs_pend || w_fs) begin
                            r_fs_pend <= 1'b0;
                            r_state   <= ST_REQ;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= BASE;
                            r_rd_len  <= LEN_FIRST;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else if (w_fs) begin
                        r_fs_pend <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (w_fs) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= BASE;
                        r_rd_len  <= LEN_FIRST;
                    end else if (r_burst_idx == '0) begin
                        // Index wrapped to zero: the burst just finished closed a line.
                        if (r_line_cnt == LC_END) begin
                            r_state <= ST_DONE;
                        end else if (r_count == 2'd2) begin
                            r_state <= ST_FULL;
                        end else begin
                            r_state   <= ST_REQ;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= r_line_addr;
                            r_rd_len  <= LEN_FIRST;
                        end
                    end else begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_W'(r_rd_len);
                        r_rd_len  <= (r_burst_idx == IDX_LAST) ? LEN_LAST : LEN_FULL;
                    end
                end
                default: r_state <= ST_WAIT_FRAME;
            endcase
        end
    end

`ifdef FETCH_UFLOW_CNT_EN
    logic [15:0] r_uflow_cnt;

    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            r_uflow_cnt <= '0;
        end else if (w_uflow && (r_uflow_cnt != '1)) begin
            r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end
    end

    assign uflow_cnt = r_uflow_cnt;
`else
    assign uflow_cnt = '0;
`endif

    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign rd_len     = r_rd_len;
    assign fetch_busy = r_fetch_busy;
    assign fill_slot  = r_fill_slot;
    assign read_slot  = r_read_slot;
    assign underflow  = r_underflow;

endmodule
